// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types and defaults for the serial frame shifter.
//   state_t   : frame sequencer states
//   DEF_WIDTH : default frame length in bits
//   DEF_DIV   : default clocks per bit
// ---------------------------------------------------------------------------
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIV   = 4;

endpackage

// File: rtl/shift_bit_timer.sv
// ---------------------------------------------------------------------------
// shift_bit_timer
// Bit-rate prescaler. Counts clocks while enabled and raises a one-cycle
// strobe on the last clock of each bit period, then restarts from zero.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high
//   clear  in  synchronous restart of the count (wins over enable)
//   enable in  count while high
//   strobe out high during the final clock of a bit period
// ---------------------------------------------------------------------------
module shift_bit_timer
   import shift_pkg::*;
#(
   parameter int DIV = DEF_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic strobe
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   // With DIV=1 the terminal value is 0, so every enabled clock strobes.
   assign strobe = enable && (div_cnt == TC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (clear) begin
         div_cnt <= '0;
      end else if (enable) begin
         div_cnt <= strobe ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/shift_frame_ctrl.sv
// ---------------------------------------------------------------------------
// shift_frame_ctrl
// Full-duplex serial frame sequencer. Takes a parallel word over valid/ready,
// shifts it out WIDTH bits at one bit every DIV clocks, captures ser_in on the
// same strobes and presents the received word with a one-cycle rx_valid.
//
// Build option: define SHIFT_LSB_FIRST_EN for LSB-first framing (transmit
// and receive); default is MSB first. Timing is the same in both builds.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high
//   tx_data   in   [WIDTH] word to send, sampled on accept
//   tx_valid  in   producer has a word
//   tx_ready  out  controller can accept (IDLE)
//   ser_out   out  serial output bit
//   ser_in    in   serial input bit, sampled on strobe edges
//   ser_en    out  one-cycle shift strobe
//   rx_data   out  [WIDTH] last received word
//   rx_valid  out  one-cycle pulse when rx_data updates
//   busy      out  high in SHIFT and DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a word; ser_out low
// SHIFT | one bit per DIV clocks; strobe shifts tx_sr/rx_sr
// DONE  | single cycle; publish rx_sr to rx_data, pulse rx_valid next
// ---------------------------------------------------------------------------
module shift_frame_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV   = DEF_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             ser_out,
   input  logic             ser_in,
   output logic             ser_en,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic [BW-1:0]    bit_cnt;
   logic             strobe;
   logic             in_shift;
   logic             timer_clear;
   logic             tx_bit;
   logic [WIDTH-1:0] tx_next;
   logic [WIDTH-1:0] rx_next;

   assign in_shift    = (state == SHIFT);
   assign timer_clear = !in_shift;

   shift_bit_timer #(
      .DIV (DIV)
   ) u_bit_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .enable (in_shift),
      .strobe (strobe)
   );

`ifdef SHIFT_LSB_FIRST_EN
   assign tx_bit  = tx_sr[0];
   assign tx_next = tx_sr >> 1;
   assign rx_next = {ser_in, rx_sr[WIDTH-1:1]};
`else
   assign tx_bit  = tx_sr[WIDTH-1];
   assign tx_next = tx_sr << 1;
   assign rx_next = {rx_sr[WIDTH-2:0], ser_in};
`endif

   // Both decode only registered state, so they are glitch-free and forced
   // low outside SHIFT (the timer strobe is already gated by in_shift).
   assign ser_out = in_shift & tx_bit;
   assign ser_en  = strobe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tx_ready <= 1'b0;
         busy     <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         bit_cnt  <= '0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               // tx_ready is registered, so it rises one clock after reset
               // release and is 1 in every IDLE cycle after that.
               tx_ready <= 1'b1;
               if (tx_valid && tx_ready) begin
                  tx_sr    <= tx_data;
                  rx_sr    <= '0;
                  bit_cnt  <= '0;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (strobe) begin
                  tx_sr <= tx_next;
                  rx_sr <= rx_next;
                  // Hold bit_cnt at its terminal value instead of wrapping.
                  if (bit_cnt == LAST_BIT) begin
                     state <= DONE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               rx_data  <= rx_sr;
               rx_valid <= 1'b1;
               busy     <= 1'b0;
               tx_ready <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_frame_ctrl
// Two instances share clock and reset: u_div4 (WIDTH=8, DIV=4) and
// u_div1 (WIDTH=8, DIV=1). 'sel' picks which one receives tx_valid and
// which one is observed. Expected behaviour comes from a frame-level model:
// bit k of a frame occupies clocks k*DIV .. k*DIV+DIV-1 after the accept
// edge, the strobe is the last clock of each bit, and the received word is
// the serial bit sequence placed by frame bit order.
// ---------------------------------------------------------------------------
module tb_shift_frame_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       ser_in_drv;
   logic       loop;
   logic       sel;

   logic       tx_valid0, tx_ready0, ser_out0, ser_in0, ser_en0, rx_valid0, busy0;
   logic       tx_valid1, tx_ready1, ser_out1, ser_in1, ser_en1, rx_valid1, busy1;
   logic [7:0] rx_data0, rx_data1;

   logic       o_ready, o_sout, o_sen, o_rxv, o_busy;
   logic [7:0] o_rxd;

   int         n_cmp;
   int         n_err;
   logic [7:0] last_rx [2];

   assign tx_valid0 = tx_valid & ~sel;
   assign tx_valid1 = tx_valid & sel;
   assign ser_in0   = loop ? ser_out0 : ser_in_drv;
   assign ser_in1   = loop ? ser_out1 : ser_in_drv;

   assign o_ready = sel ? tx_ready1 : tx_ready0;
   assign o_sout  = sel ? ser_out1  : ser_out0;
   assign o_sen   = sel ? ser_en1   : ser_en0;
   assign o_rxv   = sel ? rx_valid1 : rx_valid0;
   assign o_busy  = sel ? busy1     : busy0;
   assign o_rxd   = sel ? rx_data1  : rx_data0;

   shift_frame_ctrl #(.WIDTH(8), .DIV(4)) u_div4 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid0),
      .tx_ready(tx_ready0), .ser_out(ser_out0), .ser_in(ser_in0),
      .ser_en(ser_en0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0)
   );

   shift_frame_ctrl #(.WIDTH(8), .DIV(1)) u_div1 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid1),
      .tx_ready(tx_ready1), .ser_out(ser_out1), .ser_in(ser_in1),
      .ser_en(ser_en1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---- reference model -------------------------------------------------
   // Bit k of the frame as it appears on the wire.
   function automatic logic wire_bit(input logic [7:0] d, input int k);
`ifdef SHIFT_LSB_FIRST_EN
      return d[k];
`else
      return d[7-k];
`endif
   endfunction

   // Word formed from a serial sequence s, where s[k] is the k-th bit seen.
   function automatic logic [7:0] assemble(input logic [7:0] s);
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) begin
`ifdef SHIFT_LSB_FIRST_EN
         r[k] = s[k];
`else
         r[7-k] = s[k];
`endif
      end
      return r;
   endfunction

   // ---- comparison helpers ----------------------------------------------
   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Idle cycles: advance, then check the quiet IDLE outputs.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk1("idle_ready", o_ready, 1'b1);
         chk1("idle_busy", o_busy, 1'b0);
         chk1("idle_rx_valid", o_rxv, 1'b0);
         chk1("idle_ser_en", o_sen, 1'b0);
         chk1("idle_ser_out", o_sout, 1'b0);
         chk8("idle_rx_data", o_rxd, last_rx[sel]);
      end
   endtask

   // One frame. Entered at a negedge of an IDLE cycle; returns at the negedge
   // of the cycle carrying rx_valid. s: instance, lp: loopback, sin: serial
   // bits to feed when not looped, hold: keep tx_valid high afterwards.
   task automatic frame(input logic s, input logic [7:0] data, input logic lp,
                        input logic [7:0] sin, input logic hold);
      int         dv;
      int         n;
      int         k;
      int         en_cnt;
      logic [7:0] seq;
      logic       exp_out;
      logic       exp_en;
      sel = s;
      loop = lp;
      dv = s ? 1 : 4;
      n = 8 * dv;
      en_cnt = 0;
      chk1("pre_ready", o_ready, 1'b1);
      tx_data = data;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
      tx_data = 8'($urandom);
      for (int p = 0; p <= n; p++) begin
         k = p / dv;
         exp_out = (p < n) ? wire_bit(data, k) : 1'b0;
         exp_en  = (p < n) && ((p % dv) == dv - 1);
         chk1("ser_out", o_sout, exp_out);
         chk1("ser_en", o_sen, exp_en);
         chk1("busy", o_busy, 1'b1);
         chk1("ready_low", o_ready, 1'b0);
         chk1("rx_valid_low", o_rxv, 1'b0);
         chk8("rx_data_held", o_rxd, last_rx[s]);
         if (p < n) ser_in_drv = sin[k];
         if (o_sen === 1'b1) en_cnt++;
         @(negedge clk);
      end
      for (int b = 0; b < 8; b++) seq[b] = lp ? wire_bit(data, b) : sin[b];
      chk1("rx_valid", o_rxv, 1'b1);
      chk8("rx_data", o_rxd, assemble(seq));
      chk1("ready_back", o_ready, 1'b1);
      chk1("busy_done", o_busy, 1'b0);
      chk1("ser_out_done", o_sout, 1'b0);
      chki("ser_en_count", en_cnt, 8);
      last_rx[s] = assemble(seq);
   endtask

   // ---- directed + randomized sequence -----------------------------------
   initial begin
      logic       s;
      logic       hold;
      logic       lp;
      logic [7:0] d;
      logic [7:0] sin;
      n_cmp = 0;
      n_err = 0;
      last_rx[0] = 8'h00;
      last_rx[1] = 8'h00;
      reset = 1'b1;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      ser_in_drv = 1'b0;
      loop = 1'b0;
      sel = 1'b0;

      @(negedge clk);
      chk1("rst_ready", tx_ready0, 1'b0);
      chk1("rst_busy", busy0, 1'b0);
      chk1("rst_rx_valid", rx_valid0, 1'b0);
      chk1("rst_ser_out", ser_out0, 1'b0);
      chk1("rst_ser_en", ser_en0, 1'b0);
      chk8("rst_rx_data", rx_data0, 8'h00);
      chk1("rst_ready_div1", tx_ready1, 1'b0);
      reset = 1'b0;
      idle(2);

      // Loopback A5, MSB/LSB order per build
      frame(1'b0, 8'hA5, 1'b1, 8'h00, 1'b0);
      idle(2);
      // Bit order: single set bit, external ser_in pattern
      frame(1'b0, 8'h80, 1'b0, 8'b1011_0010, 1'b0);
      idle(1);
      frame(1'b0, 8'h01, 1'b1, 8'h00, 1'b0);
      idle(1);
      // DIV=1, ser_in tied high, zero payload
      frame(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0);
      idle(1);
      // Back-to-back with tx_valid held through the busy window
      frame(1'b0, 8'h3C, 1'b1, 8'h00, 1'b1);
      frame(1'b0, 8'h81, 1'b1, 8'h00, 1'b0);
      idle(2);

      // Randomized frames
      for (int i = 0; i < 10; i++) begin
         s    = 1'($urandom_range(0, 1));
         d    = 8'($urandom);
         sin  = 8'($urandom);
         lp   = 1'($urandom_range(0, 1));
         hold = 1'($urandom_range(0, 1));
         frame(s, d, lp, sin, hold);
         tx_valid = 1'b0;
         idle(1 + $urandom_range(0, 2));
      end

      // Reset in the middle of a frame
      sel = 1'b0;
      loop = 1'b0;
      tx_data = 8'hFF;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk1("mid_busy", busy0, 1'b1);
      chk1("mid_ser_out", ser_out0, 1'b1);
      reset = 1'b1;
      #1;
      chk1("abort_ser_out", ser_out0, 1'b0);
      chk1("abort_ser_en", ser_en0, 1'b0);
      chk1("abort_busy", busy0, 1'b0);
      chk1("abort_rx_valid", rx_valid0, 1'b0);
      chk1("abort_ready", tx_ready0, 1'b0);
      chk8("abort_rx_data", rx_data0, 8'h00);
      chk8("abort_rx_data_div1", rx_data1, 8'h00);
      last_rx[0] = 8'h00;
      last_rx[1] = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      chk1("release_ready", tx_ready0, 1'b0);
      idle(40);

      // Recovery frame after the abort
      frame(1'b0, 8'h5A, 1'b1, 8'h00, 1'b0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
